// File: rtl/ball_motion_controller.sv
// ball_motion_controller: Pong ball serve timing, direction, hit-count speed ramp and
// miss/score detection, driving the {ba,aa} speed code and serve into the ball H counter.
module ball_motion_controller #(
    parameter int unsigned SERVE_FRAMES = 64,
    parameter int unsigned HIT_MED      = 4,
    parameter int unsigned HIT_FAST     = 12
) (
    input  logic       clk7_159,
    input  logic       _reset,
    input  logic       line_tick,
    input  logic       frame_tick,
    input  logic       _attract,
    input  logic       hit_left,
    input  logic       hit_right,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       aa,
    output logic       ba,
    output logic       serve,
    output logic       dir,
    output logic [3:0] hit_count,
    output logic       score_left,
    output logic       score_right
);
    typedef enum logic [1:0] {S_SERVE, S_PLAY, S_ATTRACT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic [1:0]  phase_q, phase_d;
    logic [1:0]  code_q, code_d;
    logic [3:0]  hc_q, hc_d, hc_inc;
    logic [1:0]  level;
    logic        dir_q, dir_d;
    logic        serve_q, serve_d;
    logic        score_l_q, score_l_d;
    logic        score_r_q, score_r_d;
    logic        motion;

    always_comb begin
        level   = (hc_q < 4'(HIT_MED)) ? 2'd1 : (hc_q < 4'(HIT_FAST)) ? 2'd2 : 2'd3;
        hc_inc  = (hc_q == 4'hf) ? hc_q : hc_q + 4'd1;
        motion  = (state_q != S_SERVE) && (phase_q < level);
        phase_d = frame_tick ? 2'd0 : phase_q + 2'(line_tick);
        code_d  = line_tick ? (motion ? (dir_q ? 2'b01 : 2'b11) : 2'b10) : code_q;
        state_d   = state_q;
        timer_d   = 8'd0;
        dir_d     = dir_q;
        hc_d      = hc_q;
        score_l_d = 1'b0;
        score_r_d = 1'b0;
        case (state_q)
            S_SERVE: begin
                if (!_attract)
                    state_d = S_ATTRACT;
                else if (frame_tick && timer_q == 8'(SERVE_FRAMES - 1))
                    state_d = S_PLAY;
                else
                    timer_d = timer_q + 8'(frame_tick);
            end
            S_PLAY: begin
                // hits are tested first so a same-side hit beats a miss
                if (!_attract) begin
                    state_d = S_ATTRACT;
                end else if (hit_left && !dir_q) begin
                    dir_d = 1'b1;
                    hc_d  = hc_inc;
                end else if (hit_right && dir_q) begin
                    dir_d = 1'b0;
                    hc_d  = hc_inc;
                end else if (miss_left && !dir_q) begin
                    score_r_d = 1'b1;
                    hc_d      = 4'd0;
                    state_d   = S_SERVE;
                end else if (miss_right && dir_q) begin
                    score_l_d = 1'b1;
                    hc_d      = 4'd0;
                    state_d   = S_SERVE;
                end
            end
            S_ATTRACT: begin
                if (_attract) begin
                    state_d = S_SERVE;
                    hc_d    = 4'd0;
                end else if ((hit_left || miss_left) && !dir_q) begin
                    dir_d = 1'b1;
                end else if ((hit_right || miss_right) && dir_q) begin
                    dir_d = 1'b0;
                end
            end
            default: state_d = S_SERVE;
        endcase
        serve_d = (state_d == S_SERVE);
    end

    always_ff @(posedge clk7_159 or negedge _reset) begin
        if (!_reset) begin
            state_q   <= S_SERVE;
            timer_q   <= 8'd0;
            phase_q   <= 2'd0;
            code_q    <= 2'b10;
            hc_q      <= 4'd0;
            dir_q     <= 1'b1;
            serve_q   <= 1'b1;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            phase_q   <= phase_d;
            code_q    <= code_d;
            hc_q      <= hc_d;
            dir_q     <= dir_d;
            serve_q   <= serve_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
        end
    end

    assign {ba, aa}    = code_q;
    assign serve       = serve_q;
    assign dir         = dir_q;
    assign hit_count   = hc_q;
    assign score_left  = score_l_q;
    assign score_right = score_r_q;
endmodule

// File: tb/tb_ball_motion_controller.sv
// tb_ball_motion_controller: scoreboard bench for serve timing, hits, speed ramp, misses, attract and reset.
module tb_ball_motion_controller;
    logic       clk7_159 = 1'b0;
    logic       _reset = 1'b0;
    logic       line_tick = 1'b0, frame_tick = 1'b0, _attract = 1'b1;
    logic       hit_left = 1'b0, hit_right = 1'b0, miss_left = 1'b0, miss_right = 1'b0;
    logic       aa, ba, serve, dir, score_left, score_right;
    logic [3:0] hit_count;

    typedef struct packed {
        logic       serve;
        logic       dir;
        logic [3:0] hc;
        logic [1:0] code;
        logic       sl;
        logic       sr;
    } snap_t;

    snap_t      obs, e;
    snap_t      sb[$];
    int         passed = 0, total = 0;
    logic       e_serve, e_dir;
    logic [3:0] e_hc;
    logic [1:0] e_code;
    int         ph;

    assign obs = {serve, dir, hit_count, ba, aa, score_left, score_right};

    always #5 clk7_159 = ~clk7_159;

    ball_motion_controller #(.SERVE_FRAMES(64), .HIT_MED(4), .HIT_FAST(12)) dut (
        .clk7_159(clk7_159), ._reset(_reset), .line_tick(line_tick), .frame_tick(frame_tick),
        ._attract(_attract), .hit_left(hit_left), .hit_right(hit_right), .miss_left(miss_left),
        .miss_right(miss_right), .aa(aa), .ba(ba), .serve(serve), .dir(dir),
        .hit_count(hit_count), .score_left(score_left), .score_right(score_right)
    );

    function automatic snap_t want(input logic sl, input logic sr);
        return {e_serve, e_dir, e_hc, e_code, sl, sr};
    endfunction

    function automatic int lvl(input logic [3:0] h);
        return (h < 4) ? 1 : (h < 12) ? 2 : 3;
    endfunction

    task automatic step(input logic ft, input logic lt, input logic hl, input logic hr,
                        input logic ml, input logic mr);
        {frame_tick, line_tick, hit_left, hit_right, miss_left, miss_right} = {ft, lt, hl, hr, ml, mr};
        @(posedge clk7_159);
        #1;
        {frame_tick, line_tick, hit_left, hit_right, miss_left, miss_right} = 6'b0;
    endtask

    task automatic set_reset_expect();
        e_serve = 1'b1; e_dir = 1'b1; e_hc = 4'd0; e_code = 2'b10; ph = 0;
    endtask

    task automatic test_reset();
        set_reset_expect();
        @(negedge clk7_159);
        sb.push_back(want(1'b0, 1'b0));
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL reset_hold: got %b expected %b", obs, e); else passed++;
        _reset = 1'b1;
        sb.push_back(want(1'b0, 1'b0));
        step(0, 0, 0, 0, 0, 0);
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL reset_release: got %b expected %b", obs, e); else passed++;
    endtask

    task automatic test_serve(input string nm);
        for (int i = 1; i <= 64; i++) begin
            if (i == 64) e_serve = 1'b0;
            if (i >= 63) sb.push_back(want(1'b0, 1'b0));
            step(1, 0, 0, 0, 0, 0);
            ph = 0;
            if (i >= 63) begin
                e = sb.pop_front(); total++;
                if (obs !== e) $display("FAIL %s_frame%0d: got %b expected %b", nm, i, obs, e); else passed++;
            end
        end
    endtask

    task automatic test_lines(input string nm, input int n, input bit moving);
        sb.push_back(want(1'b0, 1'b0));
        step(1, 0, 0, 0, 0, 0);
        ph = 0;
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL %s_frame: got %b expected %b", nm, obs, e); else passed++;
        for (int i = 0; i < n; i++) begin
            e_code = (moving && ph < lvl(e_hc)) ? (e_dir ? 2'b01 : 2'b11) : 2'b10;
            ph = (ph + 1) % 4;
            sb.push_back(want(1'b0, 1'b0));
            step(0, 1, 0, 0, 0, 0);
            e = sb.pop_front(); total++;
            if (obs !== e) $display("FAIL %s_line%0d: got %b expected %b", nm, i, obs, e); else passed++;
        end
    endtask

    task automatic test_hits(input string nm, input int n);
        logic hl;
        for (int i = 0; i < n; i++) begin
            hl = !e_dir;
            e_dir = !e_dir;
            e_hc = (e_hc == 4'hf) ? 4'hf : e_hc + 4'd1;
            sb.push_back(want(1'b0, 1'b0));
            step(0, 0, hl, !hl, 0, 0);
            e = sb.pop_front(); total++;
            if (obs !== e) $display("FAIL %s_hit%0d: got %b expected %b", nm, i, obs, e); else passed++;
        end
    endtask

    task automatic test_hit();
        sb.push_back(want(1'b0, 1'b0));
        step(0, 0, 1, 0, 0, 0);
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL trailing_hit_left: got %b expected %b", obs, e); else passed++;
        e_dir = 1'b0; e_hc = 4'd1;
        sb.push_back(want(1'b0, 1'b0));
        step(0, 0, 0, 1, 0, 0);
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL hit_right: got %b expected %b", obs, e); else passed++;
        sb.push_back(want(1'b0, 1'b0));
        step(0, 0, 0, 1, 0, 0);
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL trailing_hit_right: got %b expected %b", obs, e); else passed++;
        test_lines("dir_left", 4, 1'b1);
    endtask

    task automatic test_speed();
        test_hits("ramp_a", 4);
        test_lines("level2", 8, 1'b1);
        test_hits("ramp_b", 7);
        test_lines("level3", 8, 1'b1);
        test_hits("saturate", 8);
    endtask

    task automatic test_miss();
        test_hits("to_left", 1);
        sb.push_back(want(1'b0, 1'b0));
        step(0, 0, 0, 0, 0, 1);
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL miss_against_dir: got %b expected %b", obs, e); else passed++;
        e_dir = 1'b1;
        sb.push_back(want(1'b0, 1'b0));
        step(0, 0, 1, 0, 1, 0);
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL hit_beats_miss: got %b expected %b", obs, e); else passed++;
        test_hits("to_left2", 1);
        test_lines("pre_miss", 4, 1'b1);
        e_serve = 1'b1; e_dir = 1'b0; e_hc = 4'd0;
        sb.push_back(want(1'b0, 1'b1));
        step(0, 0, 0, 0, 1, 0);
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL score_right: got %b expected %b", obs, e); else passed++;
        sb.push_back(want(1'b0, 1'b0));
        step(0, 0, 0, 0, 0, 0);
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL score_one_cycle: got %b expected %b", obs, e); else passed++;
    endtask

    task automatic test_attract();
        test_serve("serve2");
        test_hits("pre_attract", 2);
        _attract = 1'b0;
        e_serve = 1'b0;
        sb.push_back(want(1'b0, 1'b0));
        step(0, 0, 0, 0, 0, 0);
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL attract_enter: got %b expected %b", obs, e); else passed++;
        e_dir = 1'b1;
        sb.push_back(want(1'b0, 1'b0));
        step(0, 0, 1, 0, 0, 0);
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL attract_hit_frozen: got %b expected %b", obs, e); else passed++;
        e_dir = 1'b0;
        sb.push_back(want(1'b0, 1'b0));
        step(0, 0, 0, 0, 0, 1);
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL attract_miss_reflect: got %b expected %b", obs, e); else passed++;
        test_lines("attract", 4, 1'b1);
        _attract = 1'b1;
        e_serve = 1'b1; e_hc = 4'd0;
        sb.push_back(want(1'b0, 1'b0));
        step(0, 0, 0, 0, 0, 0);
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL attract_exit: got %b expected %b", obs, e); else passed++;
    endtask

    task automatic test_reset_mid();
        test_serve("serve3");
        test_hits("pre_reset", 7);
        test_lines("pre_reset", 1, 1'b1);
        #2;
        _reset = 1'b0;
        #1;
        set_reset_expect();
        sb.push_back(want(1'b0, 1'b0));
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL async_reset: got %b expected %b", obs, e); else passed++;
        @(negedge clk7_159);
        _reset = 1'b1;
        sb.push_back(want(1'b0, 1'b0));
        step(0, 0, 0, 0, 0, 0);
        e = sb.pop_front(); total++;
        if (obs !== e) $display("FAIL reset_release_mid: got %b expected %b", obs, e); else passed++;
        test_serve("serve4");
    endtask

    initial begin
        test_reset();
        test_serve("serve1");
        test_lines("level1", 5, 1'b1);
        test_hit();
        test_speed();
        test_miss();
        test_attract();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
